// File: rtl/wave_capture_ctrl.sv
// Capture controller for the 512-entry wave display RAM: arms on a rising zero
// crossing, writes 256 decimated samples into the hidden half, then swaps at frame end.
module wave_capture_ctrl #(
  parameter int SAMPLE_W = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                new_sample_ready,
  input  logic [SAMPLE_W-1:0] new_sample_in,
  input  logic [3:0]          decim,
  input  logic                frame_done,
  output logic                write_en,
  output logic [8:0]          write_address,
  output logic [7:0]          write_sample,
  output logic                read_index,
  output logic [1:0]          state
);

  localparam logic [1:0]  ST_ARMED  = 2'b00;
  localparam logic [1:0]  ST_ACTIVE = 2'b01;
  localparam logic [1:0]  ST_WAIT   = 2'b10;
  localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic        r_read_index;
  logic        r_write_en;
  logic [8:0]  r_write_address;
  logic [7:0]  r_write_sample;
  logic [7:0]  r_count;
  logic [3:0]  r_dcnt;
  logic [3:0]  r_reload;
  logic [15:0] r_tcnt;
  logic        r_prev_neg;

  logic       w_msb;
  logic [7:0] w_conv;
  logic       w_trigger;
  logic       w_unused;

  // Offset-binary top byte: flipping the sign bit maps full-scale negative to 0x00.
  assign w_msb     = new_sample_in[SAMPLE_W-1];
  assign w_conv    = {~w_msb, new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
  assign w_trigger = (r_prev_neg && !w_msb) || (r_tcnt == TCNT_LAST);
  assign w_unused  = ^new_sample_in[SAMPLE_W-9:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_ARMED;
      r_read_index    <= 1'b0;
      r_write_en      <= 1'b0;
      r_write_address <= 9'd0;
      r_write_sample  <= 8'd0;
      r_count         <= 8'd0;
      r_dcnt          <= 4'd0;
      r_reload        <= 4'd0;
      r_tcnt          <= 16'd0;
      r_prev_neg      <= 1'b0;
    end else begin
      r_write_en <= 1'b0;
      if (new_sample_ready) r_prev_neg <= w_msb;

      case (r_state)
        ST_ARMED: begin
          if (new_sample_ready) begin
            if (w_trigger) begin
              r_write_en      <= 1'b1;
              r_write_address <= {~r_read_index, 8'd0};
              r_write_sample  <= w_conv;
              r_count         <= 8'd1;
              r_dcnt          <= decim;
              r_reload        <= decim;
              r_tcnt          <= 16'd0;
              r_state         <= ST_ACTIVE;
            end else begin
              r_tcnt <= r_tcnt + 16'd1;
            end
          end
        end

        // Decimation uses the reload latched at trigger, so decim edits mid-capture are inert.
        ST_ACTIVE: begin
          if (new_sample_ready) begin
            if (r_dcnt == 4'd0) begin
              r_write_en      <= 1'b1;
              r_write_address <= {~r_read_index, r_count};
              r_write_sample  <= w_conv;
              r_count         <= r_count + 8'd1;
              r_dcnt          <= r_reload;
              if (r_count == 8'd255) r_state <= ST_WAIT;
            end else begin
              r_dcnt <= r_dcnt - 4'd1;
            end
          end
        end

        ST_WAIT: begin
          if (frame_done) begin
            r_read_index <= ~r_read_index;
            r_tcnt       <= 16'd0;
            r_state      <= ST_ARMED;
          end
        end

        default: r_state <= ST_ARMED;
      endcase
    end
  end

  assign write_en      = r_write_en;
  assign write_address = r_write_address;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;
  assign state         = r_state;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed self-checking bench for wave_capture_ctrl (TIMEOUT shortened to 8
// so the forced trigger is reachable quickly).
module tb_wave_capture_ctrl;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic [3:0]  decim;
  logic        frame_done;
  logic        write_en;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  wave_capture_ctrl #(.SAMPLE_W(16), .TIMEOUT(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .new_sample_in    (new_sample_in),
    .decim            (decim),
    .frame_done       (frame_done),
    .write_en         (write_en),
    .write_address    (write_address),
    .write_sample     (write_sample),
    .read_index       (read_index),
    .state            (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs on a falling edge and returns on the next falling
  // edge, so registered results of that cycle are visible on return.
  task automatic applyStimulus(input logic rdy, input logic [15:0] s, input logic fd);
    @(negedge clk);
    new_sample_ready = rdy;
    new_sample_in    = s;
    frame_done       = fd;
    @(negedge clk);
    new_sample_ready = 1'b0;
    frame_done       = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkWrite(input string tag, input logic expWe, input logic [8:0] expAddr,
                            input logic [7:0] expData);
    checkOutput({tag, "_we"}, 32'(write_en), 32'(expWe));
    if (expWe) begin
      checkOutput({tag, "_addr"}, 32'(write_address), 32'(expAddr));
      checkOutput({tag, "_data"}, 32'(write_sample), 32'(expData));
    end
  endtask

  initial begin
    logic [7:0] iv;
    logic [9:0] kv;

    reset = 1'b0; new_sample_ready = 1'b0; new_sample_in = 16'd0;
    decim = 4'd0; frame_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_we",    32'(write_en),      32'd0);
    checkOutput("rst_addr",  32'(write_address), 32'd0);
    checkOutput("rst_data",  32'(write_sample),  32'd0);
    checkOutput("rst_ridx",  32'(read_index),    32'd0);
    checkOutput("rst_state", 32'(state),         32'd0);
    reset = 1'b1;

    // Frame pulses while armed must not swap halves.
    applyStimulus(1'b0, 16'd0, 1'b1);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("idle_ridx",  32'(read_index), 32'd0);
    checkOutput("idle_state", 32'(state),      32'd0);

    $display("[TB] zero-crossing capture, decim=0");
    applyStimulus(1'b1, 16'hFF9C, 1'b0);
    checkWrite("neg100", 1'b0, 9'd0, 8'd0);
    applyStimulus(1'b1, 16'hFFCE, 1'b0);
    checkWrite("neg50", 1'b0, 9'd0, 8'd0);
    applyStimulus(1'b1, 16'd20, 1'b0);
    checkWrite("zc_trig", 1'b1, 9'h100, 8'h80);
    checkOutput("zc_state", 32'(state), 32'd1);
    for (int i = 1; i < 256; i++) begin
      iv = 8'(i);
      applyStimulus(1'b1, {iv, 8'h00}, (i == 255));
      checkWrite("cap1", 1'b1, {1'b1, iv}, iv ^ 8'h80);
    end
    checkOutput("cap1_wait",   32'(state),      32'd2);
    checkOutput("cap1_noswap", 32'(read_index), 32'd0);
    repeat (2) begin
      applyStimulus(1'b1, 16'h4000, 1'b0);
      checkWrite("wait_nowr", 1'b0, 9'd0, 8'd0);
    end
    checkOutput("wait_state", 32'(state), 32'd2);
    applyStimulus(1'b1, 16'hFFFF, 1'b1);
    checkWrite("swap_nowr", 1'b0, 9'd0, 8'd0);
    checkOutput("swap_ridx",  32'(read_index), 32'd1);
    checkOutput("swap_state", 32'(state),      32'd0);

    $display("[TB] capture into half 0, aborted by reset");
    applyStimulus(1'b1, 16'h0100, 1'b0);
    checkWrite("cap2_trig", 1'b1, 9'h000, 8'h81);
    for (int j = 1; j < 100; j++) begin
      iv = 8'(j);
      applyStimulus(1'b1, {iv, 8'h00}, 1'b0);
      checkWrite("cap2", 1'b1, {1'b0, iv}, iv ^ 8'h80);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_we",    32'(write_en),      32'd0);
    checkOutput("abort_ridx",  32'(read_index),    32'd0);
    checkOutput("abort_state", 32'(state),         32'd0);
    checkOutput("abort_addr",  32'(write_address), 32'd0);
    reset = 1'b1;

    $display("[TB] forced trigger then decimation by 4");
    decim = 4'd3;
    for (int n = 1; n < 8; n++) begin
      applyStimulus(1'b1, 16'd500, 1'b0);
      checkWrite("auto_wait", 1'b0, 9'd0, 8'd0);
    end
    checkOutput("auto_armed", 32'(state), 32'd0);
    applyStimulus(1'b1, 16'd500, 1'b0);
    checkWrite("auto_trig", 1'b1, 9'h100, 8'h81);
    checkOutput("auto_state", 32'(state), 32'd1);
    for (int k = 1; k <= 1020; k++) begin
      if (k == 500) decim = 4'd0;
      kv = 10'(k);
      applyStimulus(1'b1, {kv[7:0], 8'h00}, 1'b0);
      if (kv[1:0] == 2'b00) checkWrite("dec_wr", 1'b1, {1'b1, kv[9:2]}, kv[7:0] ^ 8'h80);
      else                  checkWrite("dec_skip", 1'b0, 9'd0, 8'd0);
    end
    checkOutput("dec_wait", 32'(state),      32'd2);
    checkOutput("dec_ridx", 32'(read_index), 32'd0);
    applyStimulus(1'b0, 16'd0, 1'b1);
    checkOutput("fd_ridx",  32'(read_index), 32'd1);
    checkOutput("fd_state", 32'(state),      32'd0);

    // Next crossing must land in half 0 now that half 1 is displayed.
    applyStimulus(1'b1, 16'hFFFB, 1'b0);
    checkWrite("cap4_neg", 1'b0, 9'd0, 8'd0);
    applyStimulus(1'b1, 16'd5, 1'b0);
    checkWrite("cap4_trig", 1'b1, 9'h000, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
